round_robin_sched_4x1: RTL
==========================

Name: round_robin_sched_4x1

Overview:
- Scheduler and buffer in front of the 4-lane, 4-bit selection datapath.
- Four source lanes push 4-bit words into per-lane FIFOs.
- A work-conserving round-robin arbiter picks one non-empty lane per cycle, pops its head word and drives a registered output word, valid and the 2-bit lane select.
- The select encoding matches the 4x1 mux convention: 00=lane1, 01=lane2, 10=lane3, 11=lane4.

Parameters:
- DATA_WIDTH, 4, width of each lane word and of out_data
- FIFO_DEPTH, 4, words per lane FIFO; power of two, >=2
- PTR_W, 2, log2(FIFO_DEPTH)

Ports:
- clok  in  1  single clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- bus1..bus4  in  DATA_WIDTH each  lane write data
- valid1..valid4  in  1 each  lane push request
- full1..full4  out  1 each  lane FIFO full (registered); source must hold word while high
- out_ready  in  1  downstream accepts a word this cycle
- out_data  out  DATA_WIDTH  registered selected word
- valid_out  out  1  out_data holds a new word this cycle
- selector_2bits  out  2  lane index of the current out_data
- idle  out  1  all four FIFOs empty (registered)

Behaviour:
- Reset (async assert, sync release):
  - out_data=0, valid_out=0, selector_2bits=00, full1..4=0, idle=1.
  - All FIFO pointers and counts=0.
  - last_grant=3, so lane1 wins first.
- Push, per lane:
  - Word is written when validN=1 and fullN=0 at the clock edge.
  - validN while fullN=1 drops the word; the source is responsible for holding it.
- fullN is derived from the registered count at cycle start.
  - A push on a full lane is refused even if the same lane is popped that cycle; no same-cycle slot reuse.
- Eligibility: lane is eligible when its count at cycle start >0. There is no bypass.
  - A word pushed at edge t can appear on out_data after edge t+1 at the earliest (1-cycle minimum latency).
- Arbitration, each cycle with out_ready=1 and at least one eligible lane:
  - grant = first eligible lane scanning last_grant+1, +2, +3, +4, mod 4.
  - On the edge: pop the head of the grant lane; out_data<=head; selector_2bits<=grant; valid_out<=1; last_grant<=grant.
- Throughput: one word per cycle. With all lanes backlogged the order is strictly 1,2,3,4,1,...
- No grant (out_ready=0, or all lanes empty):
  - valid_out<=0.
  - out_data and selector_2bits hold their last values.
  - last_grant unchanged; no pop.
- Simultaneous push and pop on the same non-full lane: count unchanged, FIFO order preserved.
- Count width is PTR_W+1.
  - full = (count==FIFO_DEPTH), empty = (count==0).
  - Read and write pointers wrap mod FIFO_DEPTH.
- idle is registered: 1 when every count is 0 after the edge.
- Reset asserted mid-operation:
  - Buffered words are discarded immediately.
  - Outputs go to reset values with no clock required.
  - After release, arbitration restarts at lane1.
- FSM, 2 states, registered:
  - IDLE: no lane eligible. Goes to SERVE when any count>0.
  - SERVE: arbitrating. Returns to IDLE when all counts reach 0 after a pop.
  - out_ready=0 stalls within SERVE.
  - idle = (state==IDLE), updated consistently with counts.

Decomposition:
- Shared package:
  - Lane index constants LANE1=2'b00, LANE2=2'b01, LANE3=2'b10, LANE4=2'b11.
  - State encoding IDLE/SERVE.
  - DATA_WIDTH and FIFO_DEPTH defaults.
- Sub-module lane_fifo_4bits, instantiated 4x:
  - Ports: clok, reset_L, push, pop, din, dout (head, combinational read), full, empty, count.
- Arbiter pointer, grant logic, FSM and output registers live in the top module.

Test Plan:
- Reset: hold reset_L=0 with valids active.
  - -> valid_out=0, out_data=0, selector_2bits=00, idle=1, no pushes.
  - Release reset; first push lane3 0xA -> 2 edges later out_data=0xA, selector_2bits=10, valid_out=1.
- Full backlog: preload lanes 1-4 with 0x1,0x2,0x3,0x4, then out_ready=1.
  - -> 4 consecutive valid words 0x1,0x2,0x3,0x4 with selectors 00,01,10,11.
  - idle=1 after the last one.
- Fairness: lane1 pushes every cycle, lane4 holds 0xF, out_ready=1.
  - -> lane4 is granted within 2 grants; outputs alternate lane1/lane4.
- Full/refuse: 5 pushes to lane2 (0x1..0x5) with out_ready=0.
  - -> full2=1 after the 4th push; 0x5 is dropped.
  - Then out_ready=1 -> outputs 0x1..0x4 only.
- Stall: out_ready=0 mid-stream.
  - -> valid_out=0, out_data and selector_2bits hold, no counts change.
  - Resume -> the next lane in round-robin order continues with no loss.
- Reset mid-stream: assert reset_L between edges with 3 words buffered.
  - -> outputs clear immediately; after release nothing is emitted until a new push.

Source files
------------

// File: rtl/round_robin_sched_4x1_pkg.sv
// Shared constants for the 4-lane round-robin scheduler.
// Lane encodings follow the 4x1 mux select convention.
package round_robin_sched_4x1_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] LANE1 = 2'b00;
  localparam logic [1:0] LANE2 = 2'b01;
  localparam logic [1:0] LANE3 = 2'b10;
  localparam logic [1:0] LANE4 = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  // First eligible lane after last, wrapping; last itself is the final
  // candidate. Scanning from the far end lets the nearest one win.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] last,
    input logic [3:0] elig
  );
    logic [1:0] g;
    logic [1:0] idx;
    g = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (elig[idx]) g = idx;
    end
    return g;
  endfunction

endpackage

// File: rtl/round_robin_sched_4x1_lane_fifo.sv
// Per-lane word FIFO with registered count.
// Head word is a combinational read of the current slot.
module lane_fifo_4bits
  import round_robin_sched_4x1_pkg::*;
#(
  parameter int DW    = DATA_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clok,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until counted in.
  always_ff @(posedge clok) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/round_robin_sched_4x1.sv
// Four buffered source lanes merged onto one registered output
// by a work-conserving round-robin arbiter.
module round_robin_sched_4x1
  import round_robin_sched_4x1_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clok,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] bus1,
  input  logic [DATA_WIDTH-1:0] bus2,
  input  logic [DATA_WIDTH-1:0] bus3,
  input  logic [DATA_WIDTH-1:0] bus4,
  input  logic                  valid1,
  input  logic                  valid2,
  input  logic                  valid3,
  input  logic                  valid4,
  output logic                  full1,
  output logic                  full2,
  output logic                  full3,
  output logic                  full4,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  valid_out,
  output logic [1:0]            selector_2bits,
  output logic                  idle
);

  logic [DATA_WIDTH-1:0] din_a  [4];
  logic [DATA_WIDTH-1:0] dout_a [4];
  logic [PTR_W:0]        cnt_a  [4];
  logic [3:0]            push_a;
  logic [3:0]            pop_a;
  logic [3:0]            full_a;
  logic [3:0]            empty_a;
  logic [3:0]            elig;
  logic [3:0]            nz_next;
  logic [1:0]            last_grant;
  logic [1:0]            grant;
  logic                  grant_v;
  logic [0:0]            state;
  logic [0:0]            state_nxt;

  assign din_a[0] = bus1;
  assign din_a[1] = bus2;
  assign din_a[2] = bus3;
  assign din_a[3] = bus4;
  assign push_a   = {valid4, valid3, valid2, valid1};

  assign full1 = full_a[0];
  assign full2 = full_a[1];
  assign full3 = full_a[2];
  assign full4 = full_a[3];

  assign elig    = ~empty_a;
  assign grant   = rr_pick(last_grant, elig);
  assign grant_v = out_ready & (|elig);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign pop_a[g] = grant_v & (grant == 2'(g));

    assign nz_next[g] =
      (push_a[g] & ~full_a[g]) |
      ((cnt_a[g] != '0) &
       ~((cnt_a[g] == (PTR_W+1)'(1)) & pop_a[g]));

    lane_fifo_4bits #(
      .DW    (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .PW    (PTR_W)
    ) u_fifo (
      .clok    (clok),
      .reset_L (reset_L),
      .push    (push_a[g]),
      .pop     (pop_a[g]),
      .din     (din_a[g]),
      .dout    (dout_a[g]),
      .full    (full_a[g]),
      .empty   (empty_a[g]),
      .count   (cnt_a[g])
    );
  end

  // Next state follows whether any lane holds words after this edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|nz_next)  state_nxt = ST_SERVE;
      ST_SERVE: if (!(|nz_next)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output word, select, valid and arbiter pointer update on a grant.
  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      out_data       <= '0;
      valid_out      <= 1'b0;
      selector_2bits <= LANE1;
      last_grant     <= LANE4;
      state          <= ST_IDLE;
    end else begin
      valid_out <= grant_v;
      state     <= state_nxt;
      if (grant_v) begin
        out_data       <= dout_a[grant];
        selector_2bits <= grant;
        last_grant     <= grant;
      end
    end
  end

  assign idle = (state == ST_IDLE);

endmodule
